// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with fixed access latency and pipeline stall.
// Optional misaligned-access error reporting is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqWriteData,
    output logic        ReqReady,
    output logic        Stall,
    output logic        RespValid,
    output logic [31:0] RespReadData,
    output logic        RespError
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateType;

    stateType         stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic             writeReg;
    logic [IDX_W-1:0] indexReg;
    logic [31:0]      wdataReg;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             enterResp;
    logic             curWrite;
    logic [IDX_W-1:0] curIndex;
    logic             curMisaligned;
    logic             commitOk;
    logic             unusedAddrBits;

    assign unusedAddrBits = ^ReqAddress;

    assign ReqReady  = !Reset && (stateReg == IDLE);
    assign Stall     = !Reset && (((stateReg == IDLE) && ReqValid) || (stateReg == WAIT));
    assign RespValid = (stateReg == RESP);
    assign accept    = ReqValid && ReqReady;

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            IDLE: begin
                if (ReqValid) begin
                    if (LATENCY == 1) begin
                        stateNext = RESP;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cntReg == '0) begin
                    stateNext = RESP;
                end else begin
                    cntNext = cntReg - 1'b1;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stateReg <= IDLE;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            writeReg <= ReqWrite;
            indexReg <= ReqAddress[IDX_W+1:2];
            wdataReg <= ReqWriteData;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic misReg;

    always_ff @(posedge CLK) begin
        if (accept) begin
            misReg <= (ReqAddress[1:0] != 2'b00);
        end
    end

    assign curMisaligned = (stateReg == IDLE) ? (ReqAddress[1:0] != 2'b00) : misReg;
    assign commitOk      = !misReg;
    assign RespError     = (stateReg == RESP) && misReg;
`else
    assign curMisaligned = 1'b0;
    assign commitOk      = 1'b1;
    assign RespError     = 1'b0;
`endif

    // With LATENCY=1 the RESP entry edge is also the accept edge, so take request fields live.
    assign curWrite  = (stateReg == IDLE) ? ReqWrite : writeReg;
    assign curIndex  = (stateReg == IDLE) ? ReqAddress[IDX_W+1:2] : indexReg;
    assign enterResp = !Reset && (stateNext == RESP) && (stateReg != RESP);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            RespReadData <= '0;
        end else if (enterResp) begin
            RespReadData <= (!curWrite && !curMisaligned) ? mem[curIndex] : '0;
        end
    end

    // Stores commit on the edge leaving RESP; a reset on that edge drops the store.
    always_ff @(posedge CLK) begin
        if (!Reset && (stateReg == RESP) && writeReg && commitOk) begin
            mem[indexReg] <= wdataReg;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
// Expected load data comes from a bench-side word model; honours DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;
    localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
    } expType;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv = 1'b0, rw = 1'b0;
    logic [31:0] ra = '0, rd = '0;
    logic        reqReady, stall, respValid, respError;
    logic [31:0] respData;

    logic        rv1 = 1'b0, rw1 = 1'b0;
    logic [31:0] ra1 = '0, rd1 = '0;
    logic        reqReady1, stall1, respValid1, respError1;
    logic [31:0] respData1;

    expType      sbq[$];
    logic [31:0] model [256];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .CLK(clk), .Reset(rst), .ReqValid(rv), .ReqWrite(rw), .ReqAddress(ra),
        .ReqWriteData(rd), .ReqReady(reqReady), .Stall(stall), .RespValid(respValid),
        .RespReadData(respData), .RespError(respError)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .CLK(clk), .Reset(rst), .ReqValid(rv1), .ReqWrite(rw1), .ReqAddress(ra1),
        .ReqWriteData(rd1), .ReqReady(reqReady1), .Stall(stall1), .RespValid(respValid1),
        .RespReadData(respData1), .RespError(respError1)
    );

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance, checked against the scoreboard.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        expType e;
        int     cyc;
        logic   mis;
        int     idx;
        mis    = ALIGN_EN && (a[1:0] != 2'b00);
        idx    = int'(a[9:2]);
        e.err  = mis;
        e.data = (w || mis) ? 32'h0 : model[idx];
        sbq.push_back(e);
        @(posedge clk); #1;
        rv = 1'b1; rw = w; ra = a; rd = d;
        @(negedge clk);
        chk(32'(reqReady), 32'd1, "ready_idle");
        chk(32'(stall), 32'd1, "stall_req");
        @(posedge clk); #1;
        rv = 1'b0; ra = 32'hFFFF_FFFC; rd = 32'h0;
        cyc = 1;
        @(negedge clk);
        while (respValid !== 1'b1 && cyc < 20) begin
            chk(32'(stall), 32'd1, "stall_wait");
            @(negedge clk);
            cyc++;
        end
        chk(32'(cyc), 32'(LAT), "latency");
        chk(32'(stall), 32'd0, "stall_resp");
        chk(32'(reqReady), 32'd0, "ready_resp");
        e = sbq.pop_front();
        chk(respData, e.data, "resp_data");
        chk(32'(respError), 32'(e.err), "resp_error");
        if (w && !mis) model[idx] = d;
        $display("[TB] %s addr=%h wdata=%h rdata=%h err=%0b", w ? "store" : "load ", a, d, respData, respError);
    endtask

    initial begin
        int cnt;
        // Reset state, with ReqValid high to show Stall is masked.
        rv = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(32'(reqReady), 32'd0, "rst_ready");
        chk(32'(stall), 32'd0, "rst_stall");
        chk(32'(respValid), 32'd0, "rst_valid");
        chk(respData, 32'h0, "rst_data");
        chk(32'(respError), 32'd0, "rst_error");
        @(posedge clk); #1;
        rst = 1'b0; rv = 1'b0;
        @(negedge clk);
        chk(32'(reqReady), 32'd1, "post_rst_ready");
        chk(32'(stall), 32'd0, "post_rst_stall");

        // LATENCY=1 instance: store, then back-to-back loads with ReqValid held high.
        @(posedge clk); #1;
        rv1 = 1'b1; rw1 = 1'b1; ra1 = 32'h40; rd1 = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rv1 = 1'b0;
        @(negedge clk);
        chk(32'(respValid1), 32'd1, "l1_store_valid");
        chk(32'(reqReady1), 32'd0, "l1_ready_resp");
        chk(32'(stall1), 32'd0, "l1_stall_resp");
        @(negedge clk);
        chk(32'(reqReady1), 32'd1, "l1_ready_gap");
        $display("[TB] l1 store addr=00000040 wdata=cafef00d");
        @(posedge clk); #1;
        rv1 = 1'b1; rw1 = 1'b0; ra1 = 32'h40;
        @(negedge clk);
        chk(32'(respValid1), 32'd0, "l1_no_early_valid");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk(32'(respValid1), 32'((i % 2) == 0), "l1_valid_pattern");
            if (respValid1 === 1'b1) begin
                cnt++;
                chk(respData1, 32'hCAFE_F00D, "l1_load_data");
            end
        end
        chk(32'(cnt), 32'd5, "l1_throughput");
        $display("[TB] l1 streamed loads addr=00000040 responses=%0d", cnt);
        @(posedge clk); #1;
        rv1 = 1'b0;

        // LATENCY=2 instance: store/load, hold, wrap.
        access(1'b1, 32'h10, 32'hDEAD_BEEF);
        access(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk(respData, 32'hDEAD_BEEF, "data_hold");
        access(1'b1, 32'h400, 32'h1234_5678);
        access(1'b0, 32'h000, 32'h0);

        // Reset during the RESP cycle of a store must drop the commit.
        access(1'b1, 32'h20, 32'h1111_1111);
        @(posedge clk); #1;
        rv = 1'b1; rw = 1'b1; ra = 32'h20; rd = 32'hAAAA_5555;
        @(posedge clk); #1;
        rv = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (respValid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk(32'(cnt < 20), 32'd1, "rst_resp_reached");
        rst = 1'b1;
        @(negedge clk);
        chk(32'(respValid), 32'd0, "midrst_valid");
        chk(respData, 32'h0, "midrst_data");
        chk(32'(respError), 32'd0, "midrst_error");
        chk(32'(stall), 32'd0, "midrst_stall");
        chk(32'(reqReady), 32'd0, "midrst_ready");
        $display("[TB] reset during store resp addr=00000020 wdata=aaaa5555");
        @(posedge clk); #1;
        rst = 1'b0;
        access(1'b0, 32'h20, 32'h0);

        // Misaligned store: error and no write when checking is built, plain store otherwise.
        access(1'b1, 32'h20, 32'h0BAD_CAFE);
        access(1'b1, 32'h22, 32'hFFFF_FFFF);
        access(1'b0, 32'h20, 32'h0);
        chk(respData, ALIGN_EN ? 32'h0BAD_CAFE : 32'hFFFF_FFFF, "align_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
